fp_addsub_cmp: RTL and testbench
================================

// Module: fp_addsub_cmp
// PURPOSE
// Parametrised, multi-cycle floating-point add/subtract/compare unit with a valid/ready handshake on both sides.
// It generalises the FPU add/sub/compare datapath in three ways:
// - arbitrary exponent/mantissa width (single, half, custom);
// - an explicit FSM in place of per-op gated clocks;
// - defined special-value and overflow handling.
// It sits between the FPU issue logic and the result mux, and runs one operation at a time.
// PARAMETERS
// EXP_W  8   exponent field width (>=3)
// MAN_W  23  stored mantissa field width (>=2); operand width W = 1+EXP_W+MAN_W
// PORTS
// clk        in   1  clock, all logic on rising edge
// rst_n      in   1  asynchronous active-low reset
// in_valid   in   1  operands/opcode valid
// in_ready   out  1  unit idle, can accept
// in_opc     in   2  00 add, 01 sub (A-B), 10 compare, 11 reserved
// in_a       in   W  operand A
// in_b       in   W  operand B
// out_valid  out  1  result valid, held until out_ready
// out_ready  in   1  consumer accepts result
// out_result out  W  sum/difference (0 for compare/reserved)
// out_aeb    out  1  A==B (compare only, else 0)
// out_alb    out  1  A<B  (compare only, else 0)
// out_agb    out  1  A>B  (compare only, else 0)
// out_nan    out  1  invalid: NaN operand or inf-inf
// out_ovf    out  1  result saturated to max finite
// BEHAVIOUR
// - Reset (any time, incl. mid-operation): state IDLE, all outputs 0; the op in flight is dropped and never produces out_valid.
// - States: IDLE, ALIGN, ADD, NORM, PACK, DONE.
// - in_ready = (state==IDLE); out_valid = (state==DONE).
// - Accept on in_valid&&in_ready: register opc, A and B. Later input changes are ignored.
// - Single-cycle paths (IDLE->DONE on the next edge): compare, reserved opcode, or any special operand (NaN/inf/zero).
// - Normal add/sub path:
//   - IDLE->ALIGN: swap so |X|>=|Y|, then right-shift Y mantissa by the exponent difference, keeping guard/round/sticky bits.
//   - ALIGN->ADD: effective add/sub of magnitudes. A carry-out right-shifts by 1 and increments the exponent in the same cycle.
//   - ADD->NORM: left-shift 1 bit per cycle, decrementing the exponent, until the hidden bit is set, the exponent reaches 1, or the mantissa is zero. 0..MAN_W+3 cycles.
//   - NORM->PACK: truncate toward zero (round-to-zero mode only) and assemble the result.
//   - PACK->DONE.
//   - Latency accept->out_valid = 4+N cycles, N = NORM shifts.
// - DONE: outputs held stable; DONE->IDLE on out_ready. No new accept in the cycle DONE exits; next accept earliest one cycle later.
// - Operand classes:
//   - exp==0 is zero (denormals flushed, sign kept);
//   - exp all-ones with mantissa 0 is inf;
//   - exp all-ones with mantissa !=0 is NaN.
// - Specials (add/sub; sub negates B's sign first):
//   - any NaN, or inf + (-inf) -> canonical qNaN {0, 1..1, 1, 0..0}, out_nan=1;
//   - inf op finite -> that inf;
//   - x + 0 -> x;
//   - 0 + 0 -> -0 only if both are -0, else +0.
// - Exact zero result (x-x) -> +0.
// - Result exp >= all-ones -> max finite {s, 1..10, 1..1}, out_ovf=1.
// - Result exp < 1 after normalisation -> signed zero.
// - Compare: +0 == -0. Any NaN -> aeb=alb=agb=0, out_nan=1. Ordering is on sign-magnitude; inf is compared normally.
// - Reserved opcode: result 0, all flags 0.
// TESTING
// - add 3F800000+40000000 -> 40400000, flags 0, out_valid exactly 4 cycles after accept (N=0).
// - sub 3F800000-3F7FFFFF -> 33800000; NORM takes 24 cycles; in_valid held high is not re-accepted until DONE exits.
// - sub 3F800000-3F800000 -> 00000000; add 80000000+80000000 -> 80000000; add 7F800000+FF800000 -> 7FC00000, nan=1.
// - add 7F7FFFFF+7F7FFFFF -> 7F7FFFFF, ovf=1.
//   compare 80000000 vs 00000000 -> aeb=1; BF800000 vs 3F800000 -> alb=1; 7FC00000 vs 3F800000 -> all 0, nan=1.
// - out_ready low 5 cycles in DONE -> result/flags stable, in_ready 0. rst_n pulsed low during NORM -> outputs 0 immediately, no out_valid.
// - EXP_W=5, MAN_W=10: add 3C00+3C00 -> 4000; sub 3C00-4000 -> BC00; add 7BFF+7BFF -> 7BFF, ovf=1.

Source files
------------

// File: rtl/fp_addsub_cmp.sv
// Multi-cycle parametrised FP add/sub/compare, one op at a time, valid/ready on both sides.
// Latency 4+N cycles for normal add/sub (N = normalise shifts); specials/compare finish on the accept edge.
module fp_addsub_cmp #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_opc,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic                   out_aeb,
  output logic                   out_alb,
  output logic                   out_agb,
  output logic                   out_nan,
  output logic                   out_ovf
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam int M = MAN_W + 4;  // hidden + mantissa + guard/round/sticky
  localparam int E = EXP_W + 1;  // one spare bit to see carry into all-ones
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic             sgn_q, sgn_d, sub_q, sub_d;
  logic [E-1:0]     exp_q, exp_d;
  logic [M-1:0]     mx_q, mx_d, my_q, my_d;
  logic             aeb_q, aeb_d, alb_q, alb_d, agb_q, agb_d, nan_q, nan_d, ovf_q, ovf_d;

  // Input operand decode (B carries its effective sign for subtraction)
  logic             a_s, b_s, b_se;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_m, b_m;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
  logic [W-2:0]     a_mag, b_mag;
  logic             a_sn, b_sn, cmp_eq, cmp_gt;

  assign a_s    = in_a[W-1];
  assign a_e    = in_a[W-2:MAN_W];
  assign a_m    = in_a[MAN_W-1:0];
  assign b_s    = in_b[W-1];
  assign b_e    = in_b[W-2:MAN_W];
  assign b_m    = in_b[MAN_W-1:0];
  assign b_se   = in_opc[0] ? ~b_s : b_s;
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);
  assign a_inf  = (a_e == EXP_ONES) && (a_m == '0);
  assign b_inf  = (b_e == EXP_ONES) && (b_m == '0);
  assign a_nan  = (a_e == EXP_ONES) && (a_m != '0);
  assign b_nan  = (b_e == EXP_ONES) && (b_m != '0);
  assign special = in_opc[1] | a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

  // Zeros collapse to +0 so that +0 == -0 in sign-magnitude ordering
  always_comb begin
    a_mag  = a_zero ? '0 : in_a[W-2:0];
    b_mag  = b_zero ? '0 : in_b[W-2:0];
    a_sn   = a_s & ~a_zero;
    b_sn   = b_s & ~b_zero;
    cmp_eq = (a_sn == b_sn) && (a_mag == b_mag);
    if (a_sn != b_sn)  cmp_gt = ~a_sn;
    else if (!a_sn)    cmp_gt = (a_mag > b_mag);
    else               cmp_gt = (a_mag < b_mag);
  end

  // Alignment from registered operands: X is the larger magnitude
  logic             a_big, x_s;
  logic [EXP_W-1:0] x_e, y_e, shamt;
  logic [MAN_W-1:0] x_m, y_m;
  logic [M-1:0]     y_full, y_sh;
  logic             y_stk;
  logic [M:0]       sum;

  always_comb begin
    a_big  = (a_q[W-2:0] >= b_q[W-2:0]);
    x_s    = a_big ? a_q[W-1] : b_q[W-1];
    x_e    = a_big ? a_q[W-2:MAN_W] : b_q[W-2:MAN_W];
    x_m    = a_big ? a_q[MAN_W-1:0] : b_q[MAN_W-1:0];
    y_e    = a_big ? b_q[W-2:MAN_W] : a_q[W-2:MAN_W];
    y_m    = a_big ? b_q[MAN_W-1:0] : a_q[MAN_W-1:0];
    shamt  = x_e - y_e;
    y_full = {1'b1, y_m, 3'b000};
    y_sh   = y_full >> shamt;
    y_stk  = ((y_sh << shamt) != y_full);
    sum    = sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sgn_d   = sgn_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    mx_d    = mx_q;
    my_d    = my_q;
    aeb_d   = aeb_q;
    alb_d   = alb_q;
    agb_d   = agb_q;
    nan_d   = nan_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = {b_se, in_b[W-2:0]};
          res_d   = '0;
          aeb_d   = 1'b0;
          alb_d   = 1'b0;
          agb_d   = 1'b0;
          nan_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = special ? S_DONE : S_ALIGN;
          if (in_opc[1]) begin
            if (!in_opc[0]) begin
              if (a_nan || b_nan) begin
                nan_d = 1'b1;
              end else begin
                aeb_d = cmp_eq;
                agb_d = cmp_gt;
                alb_d = !cmp_eq && !cmp_gt;
              end
            end
          end else if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_se))) begin
            res_d = QNAN;
            nan_d = 1'b1;
          end else if (a_inf) begin
            res_d = in_a;
          end else if (b_inf) begin
            res_d = {b_se, in_b[W-2:0]};
          end else if (a_zero && b_zero) begin
            res_d = {a_s & b_se, {(W-1){1'b0}}};
          end else if (a_zero) begin
            res_d = {b_se, in_b[W-2:0]};
          end else if (b_zero) begin
            res_d = in_a;
          end
        end
      end
      S_ALIGN: begin
        sgn_d   = x_s;
        sub_d   = a_q[W-1] ^ b_q[W-1];
        exp_d   = {1'b0, x_e};
        mx_d    = {1'b1, x_m, 3'b000};
        my_d    = {y_sh[M-1:1], y_sh[0] | y_stk};
        state_d = S_ADD;
      end
      S_ADD: begin
        if (sum[M]) begin
          mx_d  = {sum[M:2], sum[1] | sum[0]};
          exp_d = exp_q + E'(1);
        end else begin
          mx_d  = sum[M-1:0];
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        if (mx_q[M-1] || (exp_q == E'(1)) || (mx_q == '0)) begin
          state_d = S_PACK;
        end else begin
          mx_d  = mx_q << 1;
          exp_d = exp_q - E'(1);
        end
      end
      S_PACK: begin
        ovf_d = 1'b0;
        // Truncation toward zero: guard/round/sticky are simply dropped
        if (mx_q == '0) begin
          res_d = '0;
        end else if (exp_q >= {1'b0, EXP_ONES}) begin
          res_d = {sgn_q, EXP_MAXF, {MAN_W{1'b1}}};
          ovf_d = 1'b1;
        end else if (!mx_q[M-1]) begin
          res_d = {sgn_q, {(W-1){1'b0}}};
        end else begin
          res_d = {sgn_q, exp_q[EXP_W-1:0], mx_q[M-2:3]};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sgn_q   <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      aeb_q   <= 1'b0;
      alb_q   <= 1'b0;
      agb_q   <= 1'b0;
      nan_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sgn_q   <= sgn_d;
      sub_q   <= sub_d;
      exp_q   <= exp_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      aeb_q   <= aeb_d;
      alb_q   <= alb_d;
      agb_q   <= agb_d;
      nan_q   <= nan_d;
      ovf_q   <= ovf_d;
    end
  end

  logic done;
  assign done       = (state_q == S_DONE);
  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = done;
  assign out_result = done ? res_q : '0;
  assign out_aeb    = done & aeb_q;
  assign out_alb    = done & alb_q;
  assign out_agb    = done & agb_q;
  assign out_nan    = done & nan_q;
  assign out_ovf    = done & ovf_q;

endmodule

// File: tb/tb_fp_addsub_cmp.sv
// Directed bench for fp_addsub_cmp: single-precision and half-precision instances,
// expected results queued at issue and compared when out_valid rises.
module tb_fp_addsub_cmp;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        sp_in_valid, sp_in_ready, sp_out_valid, sp_out_ready;
  logic [1:0]  sp_in_opc;
  logic [31:0] sp_in_a, sp_in_b, sp_out_result;
  logic        sp_aeb, sp_alb, sp_agb, sp_nan, sp_ovf;

  logic        hp_in_valid, hp_in_ready, hp_out_valid, hp_out_ready;
  logic [1:0]  hp_in_opc;
  logic [15:0] hp_in_a, hp_in_b, hp_out_result;
  logic        hp_aeb, hp_alb, hp_agb, hp_nan, hp_ovf;

  fp_addsub_cmp u_sp (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sp_in_valid), .in_ready(sp_in_ready), .in_opc(sp_in_opc),
    .in_a(sp_in_a), .in_b(sp_in_b),
    .out_valid(sp_out_valid), .out_ready(sp_out_ready), .out_result(sp_out_result),
    .out_aeb(sp_aeb), .out_alb(sp_alb), .out_agb(sp_agb), .out_nan(sp_nan), .out_ovf(sp_ovf)
  );

  fp_addsub_cmp #(.EXP_W(5), .MAN_W(10)) u_hp (
    .clk(clk), .rst_n(rst_n),
    .in_valid(hp_in_valid), .in_ready(hp_in_ready), .in_opc(hp_in_opc),
    .in_a(hp_in_a), .in_b(hp_in_b),
    .out_valid(hp_out_valid), .out_ready(hp_out_ready), .out_result(hp_out_result),
    .out_aeb(hp_aeb), .out_alb(hp_alb), .out_agb(hp_agb), .out_nan(hp_nan), .out_ovf(hp_ovf)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_AEB  = 5'b10000;
  localparam logic [4:0] F_ALB  = 5'b01000;
  localparam logic [4:0] F_AGB  = 5'b00100;
  localparam logic [4:0] F_NAN  = 5'b00010;
  localparam logic [4:0] F_OVF  = 5'b00001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic obs_valid(input bit hp);
    return hp ? hp_out_valid : sp_out_valid;
  endfunction
  function automatic logic obs_ready(input bit hp);
    return hp ? hp_in_ready : sp_in_ready;
  endfunction
  function automatic logic [31:0] obs_res(input bit hp);
    return hp ? {16'h0, hp_out_result} : sp_out_result;
  endfunction
  function automatic logic [4:0] obs_flg(input bit hp);
    return hp ? {hp_aeb, hp_alb, hp_agb, hp_nan, hp_ovf} : {sp_aeb, sp_alb, sp_agb, sp_nan, sp_ovf};
  endfunction

  task automatic drive(input bit hp, input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b, input logic v);
    if (hp) begin
      hp_in_valid = v; hp_in_opc = opc; hp_in_a = a[15:0]; hp_in_b = b[15:0];
    end else begin
      sp_in_valid = v; sp_in_opc = opc; sp_in_a = a; sp_in_b = b;
    end
  endtask

  task automatic set_ordy(input bit hp, input logic v);
    if (hp) hp_out_ready = v;
    else    sp_out_ready = v;
  endtask

  task automatic run_op(input string tag, input bit hp, input logic [1:0] opc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [4:0] ef, input int lat,
                        input int hold, input bit keep);
    exp_t e;
    int   cyc;
    bit   rdy_seen, stable;
    logic [31:0] r0;
    logic [4:0]  f0;
    check({tag, ":in_ready"}, 32'(obs_ready(hp)), 32'd1);
    drive(hp, opc, a, b, 1'b1);
    sb.push_back('{er, ef, lat});
    @(posedge clk); #1;
    if (!keep) drive(hp, 2'b00, 32'h0, 32'h0, 1'b0);
    cyc = 0;
    rdy_seen = 1'b0;
    while (!obs_valid(hp) && cyc < 200) begin
      if (obs_ready(hp)) rdy_seen = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ":valid"}, 32'(obs_valid(hp)), 32'd1);
    e = sb.pop_front();
    check({tag, ":result"}, obs_res(hp), e.res);
    check({tag, ":flags"}, 32'(obs_flg(hp)), 32'(e.flg));
    if (e.lat >= 0) check({tag, ":latency"}, 32'(cyc), 32'(e.lat));
    if (keep) begin
      check({tag, ":no_reaccept"}, 32'(rdy_seen), 32'd0);
      check({tag, ":done_rdy"}, 32'(obs_ready(hp)), 32'd0);
    end
    if (hold > 0) begin
      r0 = obs_res(hp);
      f0 = obs_flg(hp);
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (obs_res(hp) !== r0 || obs_flg(hp) !== f0 || obs_ready(hp) !== 1'b0 || obs_valid(hp) !== 1'b1)
          stable = 1'b0;
      end
      check({tag, ":hold_stable"}, 32'(stable), 32'd1);
    end
    set_ordy(hp, 1'b1);
    drive(hp, 2'b00, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    set_ordy(hp, 1'b0);
    check({tag, ":released"}, 32'(obs_valid(hp)), 32'd0);
    check({tag, ":idle_rdy"}, 32'(obs_ready(hp)), 32'd1);
  endtask

  initial begin
    bit late_valid;
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    sp_out_ready = 1'b0;
    hp_out_ready = 1'b0;
    #1;
    check("reset_valid", 32'(sp_out_valid), 32'd0);
    check("reset_result", sp_out_result, 32'h0);
    check("reset_flags", 32'(obs_flg(1'b0)), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 32'(sp_in_ready), 32'd1);

    run_op("add_1p2",      0, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, F_NONE, 4,  0, 0);
    run_op("sub_norm24",   0, 2'b01, 32'h3F800000, 32'h3F7FFFFF, 32'h33800000, F_NONE, 28, 0, 1);
    run_op("sub_exact0",   0, 2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000, F_NONE, -1, 0, 0);
    run_op("add_negzero",  0, 2'b00, 32'h80000000, 32'h80000000, 32'h80000000, F_NONE, -1, 0, 0);
    run_op("add_inf_ninf", 0, 2'b00, 32'h7F800000, 32'hFF800000, 32'h7FC00000, F_NAN,  -1, 0, 0);
    run_op("add_ovf",      0, 2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, F_OVF,  4,  0, 0);
    run_op("cmp_zeros",    0, 2'b10, 32'h80000000, 32'h00000000, 32'h0,        F_AEB,  -1, 0, 0);
    run_op("cmp_lt",       0, 2'b10, 32'hBF800000, 32'h3F800000, 32'h0,        F_ALB,  -1, 0, 0);
    run_op("cmp_nan",      0, 2'b10, 32'h7FC00000, 32'h3F800000, 32'h0,        F_NAN,  -1, 0, 0);
    run_op("cmp_gt",       0, 2'b10, 32'h40000000, 32'h3F800000, 32'h0,        F_AGB,  -1, 0, 0);
    run_op("cmp_neg_gt",   0, 2'b10, 32'hBF800000, 32'hC0000000, 32'h0,        F_AGB,  -1, 0, 0);
    run_op("reserved",     0, 2'b11, 32'h3F800000, 32'h3F800000, 32'h0,        F_NONE, -1, 0, 0);
    run_op("add_x_zero",   0, 2'b00, 32'h3F800000, 32'h00000000, 32'h3F800000, F_NONE, -1, 0, 0);
    run_op("sub_inf",      0, 2'b01, 32'h3F800000, 32'h7F800000, 32'hFF800000, F_NONE, -1, 0, 0);
    run_op("add_hold",     0, 2'b00, 32'h40000000, 32'h40000000, 32'h40800000, F_NONE, 4,  5, 0);
    run_op("add_mixed",    0, 2'b00, 32'h3FC00000, 32'hBE800000, 32'h3FA00000, F_NONE, 4,  0, 0);
    run_op("sub_underflow",0, 2'b01, 32'h00800000, 32'h00C00000, 32'h80000000, F_NONE, 4,  0, 0);
    run_op("add_truncate", 0, 2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000, F_NONE, 4,  0, 0);
    run_op("sub_small",    0, 2'b01, 32'h3F800000, 32'h33800000, 32'h3F7FFFFF, F_NONE, 5,  0, 0);

    run_op("hp_add",       1, 2'b00, 32'h3C00, 32'h3C00, 32'h4000, F_NONE, 4, 0, 0);
    run_op("hp_sub",       1, 2'b01, 32'h3C00, 32'h4000, 32'hBC00, F_NONE, 5, 0, 0);
    run_op("hp_ovf",       1, 2'b00, 32'h7BFF, 32'h7BFF, 32'h7BFF, F_OVF,  4, 0, 0);

    // Reset while the long subtraction is still normalising
    drive(1'b0, 2'b01, 32'h3F800000, 32'h3F7FFFFF, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_valid", 32'(sp_out_valid), 32'd0);
    check("midreset_result", sp_out_result, 32'h0);
    check("midreset_flags", 32'(obs_flg(1'b0)), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    late_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (sp_out_valid) late_valid = 1'b1;
    end
    check("midreset_no_valid", 32'(late_valid), 32'd0);
    run_op("after_reset",  0, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, F_NONE, 4, 0, 0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
